// File: rtl/note_pwm_mixer.sv
// Mixes enabled note square waves into one PWM speaker bit and sequences the amp enable.
// Latency: inputs -> active_cnt 2 clk; duty loads at period end; pwm_out 1 clk behind pwm_cnt.
module note_pwm_mixer #(
  parameter int NUM_VOICES  = 8,
  parameter int PWM_BITS    = 8,
  parameter int IDLE_CYCLES = 1000000,
  parameter int WAKE_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_VOICES-1:0]           voice_sq,
  input  logic [NUM_VOICES-1:0]           voice_en,
  input  logic [1:0]                      vol_shift,
  output logic                            pwm_out,
  output logic                            amp_en,
  output logic                            sample_stb,
  output logic [$clog2(NUM_VOICES):0]     active_cnt
);

  localparam int CW   = $clog2(NUM_VOICES) + 1;
  localparam int DW   = PWM_BITS + 1;
  localparam int STEP = (1 << PWM_BITS) / NUM_VOICES;
  localparam int IW   = $clog2(IDLE_CYCLES + 1);
  localparam int WW   = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {OFF, WAKE, ACTIVE, DRAIN} state_t;

  state_t                state;
  logic [NUM_VOICES-1:0] voice_sq_r;
  logic [NUM_VOICES-1:0] voice_en_r;
  logic [1:0]            vol_shift_r;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [DW-1:0]         duty;
  logic [IW-1:0]         idle_cnt;
  logic [WW-1:0]         wake_cnt;
  logic [CW-1:0]         hits_cnt;
  logic [DW-1:0]         duty_next;
  logic                  any_en;
  logic                  period_end;

  always_comb begin
    hits_cnt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      hits_cnt = hits_cnt + CW'(voice_sq_r[i] & voice_en_r[i]);
    end
  end

  // Full scale (all voices high) lands exactly on 2^PWM_BITS, hence the extra duty bit.
  assign duty_next  = (DW'(active_cnt) * DW'(STEP)) >> vol_shift_r;
  assign any_en     = |voice_en_r;
  assign period_end = &pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_sq_r  <= '0;
      voice_en_r  <= '0;
      vol_shift_r <= '0;
      active_cnt  <= '0;
      pwm_cnt     <= '0;
      duty        <= '0;
      sample_stb  <= 1'b0;
    end else begin
      voice_sq_r  <= voice_sq;
      voice_en_r  <= voice_en;
      vol_shift_r <= vol_shift;
      active_cnt  <= hits_cnt;
      pwm_cnt     <= pwm_cnt + 1'b1;
      sample_stb  <= period_end;
      if (period_end) begin
        duty <= duty_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      idle_cnt <= '0;
      wake_cnt <= '0;
      amp_en   <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      amp_en  <= (state != OFF);
      pwm_out <= (state == ACTIVE) && ({1'b0, pwm_cnt} < duty);
      case (state)
        OFF: begin
          if (any_en) begin
            state    <= WAKE;
            wake_cnt <= '0;
          end
        end
        WAKE: begin
          // Wake always runs to completion so the amp sees a full settle time.
          if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
            state <= ACTIVE;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (!any_en) begin
            state    <= DRAIN;
            idle_cnt <= '0;
          end
        end
        DRAIN: begin
          if (any_en) begin
            state <= ACTIVE;
          end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
            state <= OFF;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_note_pwm_mixer.sv
// Directed bench for note_pwm_mixer with a cycle-level reference model and hand-computed spot checks.
module tb_note_pwm_mixer;

  localparam int NV   = 8;
  localparam int PB   = 8;
  localparam int IDLE = 100;
  localparam int WAKE = 16;
  localparam int PER  = 1 << PB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] voice_sq = '0;
  logic [7:0] voice_en = '0;
  logic [1:0] vol_shift = '0;
  logic       pwm_out;
  logic       amp_en;
  logic       sample_stb;
  logic [3:0] active_cnt;

  int tests = 0;
  int fails = 0;
  int cmp_fail_prints = 0;

  note_pwm_mixer #(
    .NUM_VOICES(NV), .PWM_BITS(PB), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .voice_sq(voice_sq), .voice_en(voice_en),
    .vol_shift(vol_shift), .pwm_out(pwm_out), .amp_en(amp_en),
    .sample_stb(sample_stb), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: amp mode 0=off 1=waking 2=playing 3=draining, with time spent in that mode.
  int m_mode = 0, m_time = 0;
  int m_phase = 0, m_duty = 0, m_active = 0;
  int m_en = 0, m_sq = 0, m_vs = 0;
  int m_pwm = 0, m_amp = 0, m_stb = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_time = 0; m_phase = 0; m_duty = 0; m_active = 0;
      m_en = 0; m_sq = 0; m_vs = 0; m_pwm = 0; m_amp = 0; m_stb = 0;
    end else begin
      int p_mode, p_phase, p_duty, p_active, p_en, p_sq, p_vs;
      p_mode = m_mode; p_phase = m_phase; p_duty = m_duty; p_active = m_active;
      p_en = m_en; p_sq = m_sq; p_vs = m_vs;
      m_en = int'(voice_en); m_sq = int'(voice_sq); m_vs = int'(vol_shift);
      m_active = $countones(p_sq & p_en);
      m_phase  = (p_phase + 1) % PER;
      m_stb    = (p_phase == PER - 1) ? 1 : 0;
      if (p_phase == PER - 1) m_duty = (p_active * (PER / NV)) / (1 << p_vs);
      m_pwm = (p_mode == 2 && p_phase < p_duty) ? 1 : 0;
      m_amp = (p_mode != 0) ? 1 : 0;
      case (p_mode)
        0: if (p_en != 0) begin m_mode = 1; m_time = 0; end
        1: if (m_time == WAKE - 1) m_mode = 2; else m_time = m_time + 1;
        2: if (p_en == 0) begin m_mode = 3; m_time = 0; end
        default: begin
          if (p_en != 0) m_mode = 2;
          else if (m_time == IDLE - 1) m_mode = 0;
          else m_time = m_time + 1;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      tests++;
      if (int'(pwm_out) != m_pwm || int'(amp_en) != m_amp ||
          int'(sample_stb) != m_stb || int'(active_cnt) != m_active) begin
        fails++;
        if (cmp_fail_prints < 20) begin
          cmp_fail_prints++;
          $display("FAIL model_cmp t=%0t: pwm/amp/stb/cnt got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                   $time, pwm_out, amp_en, sample_stb, active_cnt, m_pwm, m_amp, m_stb, m_active);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for the next duty load, then counts pwm_out highs over one full period.
  task automatic measure(input int chg_at, input logic [1:0] chg_vs, output int highs);
    int n;
    n = 0;
    highs = 0;
    while (!sample_stb && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!sample_stb) check("stb_timeout", n, -1);
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == chg_at) vol_shift = chg_vs;
      if (pwm_out) highs++;
    end
  endtask

  initial begin
    int h, n, cnt_a, cnt_b, cnt_c;

    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_amp", int'(amp_en), 0);
    check("rst_stb", int'(sample_stb), 0);
    check("rst_cnt", int'(active_cnt), 0);

    // Idle with nothing enabled: one duty strobe in 500 cycles, amp and speaker quiet.
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cnt_a += int'(sample_stb);
      cnt_b += int'(amp_en);
      cnt_c += int'(pwm_out);
    end
    check("idle_stb_pulses", cnt_a, 1);
    check("idle_amp_high", cnt_b, 0);
    check("idle_pwm_high", cnt_c, 0);

    // One key: amp wakes, then 32/256 duty.
    voice_en = 8'h01; voice_sq = 8'h01;
    n = 0;
    do begin @(negedge clk); n++; end while (!amp_en && n < 50);
    check("wake_amp_latency", n, 3);
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("single_voice_highs", h, 32);

    voice_en = 8'hFF; voice_sq = 8'hFF; vol_shift = 2'd0;
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("full_vol0_highs", h, 256);
    vol_shift = 2'd2;
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("full_vol2_highs", h, 64);
    measure(100, 2'd0, h);
    check("vol_change_midperiod", h, 64);
    measure(-1, 2'd0, h);
    check("vol_change_next", h, 256);
    vol_shift = 2'd3; voice_en = 8'h01; voice_sq = 8'h01;
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("single_vol3_highs", h, 4);

    vol_shift = 2'd0; voice_en = 8'h0F; voice_sq = 8'h05;
    repeat (3) @(negedge clk);
    check("active_cnt_0f_05", int'(active_cnt), 2);
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("two_voice_highs", h, 64);
    voice_sq = 8'h00;
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("silent_keys_highs", h, 0);
    voice_en = 8'hFF;
    measure(-1, 2'd0, h);
    measure(-1, 2'd0, h);
    check("all_en_all_low_highs", h, 0);

    // Release all keys: amp holds through the drain window then drops.
    voice_en = 8'h00;
    cnt_b = 0; n = 0;
    do begin @(negedge clk); n++; cnt_b += int'(amp_en); end while (amp_en && n < 300);
    check("drain_amp_high_cycles", cnt_b, 102);

    voice_en = 8'h01; voice_sq = 8'h01;
    repeat (40) @(negedge clk);
    check("rewake_amp", int'(amp_en), 1);
    voice_en = 8'h00;
    repeat (100) @(negedge clk);
    voice_en = 8'h01;
    cnt_a = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!amp_en) cnt_a++;
    end
    check("reassert_at_timeout_amp_low", cnt_a, 0);

    // Asynchronous reset while the speaker bit is high.
    voice_en = 8'hFF; voice_sq = 8'hFF;
    measure(-1, 2'd0, h);
    repeat (50) @(negedge clk);
    check("pre_reset_pwm", int'(pwm_out), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_amp", int'(amp_en), 0);
    check("async_rst_stb", int'(sample_stb), 0);
    check("async_rst_cnt", int'(active_cnt), 0);
    @(negedge clk);
    voice_en = 8'h00;
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!sample_stb && n < 300);
    check("post_reset_first_stb", n, 256);
    check("post_reset_amp", int'(amp_en), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/note_pwm_mixer.md
Name: note_pwm_mixer

Overview:
- Downstream of the per-note square-wave generators.
- Takes the eight note square waves and their enables, and counts how many enabled voices are high.
- Turns that count into a duty value, scaled by a volume setting, and drives one PWM bit to the speaker pin.
- Also controls the external amplifier enable: shuts the amp down after a stretch with no keys held, and runs a wake-up sequence (output held low) before sound resumes.

Parameters:
NUM_VOICES, 8, number of voice inputs; must be a power of two, 2..16
PWM_BITS, 8, PWM counter width; PWM period = 2^PWM_BITS clk cycles
IDLE_CYCLES, 1000000, cycles with no enabled voice before the amp shuts down
WAKE_CYCLES, 1024, cycles the PWM is forced low after the amp is re-enabled

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
voice_sq  input  NUM_VOICES  square-wave level per note (speaker bit of each note generator)
voice_en  input  NUM_VOICES  note enable per voice (from the key LUT)
vol_shift  input  2  attenuation: duty is right-shifted by this amount (0 = full volume)
pwm_out  output  1  PWM audio bit to the speaker
amp_en  output  1  external amplifier enable, active high
sample_stb  output  1  one-cycle pulse on the cycle the new duty is loaded
active_cnt  output  $clog2(NUM_VOICES)+1  registered count of enabled voices whose level is high

Behaviour:
Reset (rst_n low, asynchronous) clears:
- pwm_cnt = 0, duty = 0, pwm_out = 0, amp_en = 0, sample_stb = 0, active_cnt = 0
- idle/wake counters = 0, FSM = OFF

Input stage:
- voice_sq, voice_en and vol_shift are registered every cycle (one stage).
- active_cnt = popcount(voice_sq_r & voice_en_r), registered; 1-cycle lag behind the input registers.

PWM counter:
- pwm_cnt free-runs 0 .. 2^PWM_BITS-1, then wraps to 0.
- It runs in every FSM state.

Duty load:
- On the cycle pwm_cnt == 2^PWM_BITS-1, duty <= (active_cnt * STEP) >> vol_shift, where STEP = 2^PWM_BITS / NUM_VOICES.
- duty is PWM_BITS+1 bits wide, so an all-high full-volume input gives duty = 2^PWM_BITS, i.e. always high. There is no overflow and no saturation.
- sample_stb is high on that same cycle only.
- Duty only changes at the period boundary; no mid-period glitching.

PWM output:
- pwm_out (registered) = (pwm_cnt < duty) when FSM == ACTIVE, else 0.
- It reflects pwm_cnt with 1 cycle of latency.

Amplifier FSM (any_en = |voice_en_r):
- OFF: amp_en = 0. any_en -> WAKE, with the wake counter cleared.
- WAKE: amp_en = 1, pwm forced 0, wake counter increments. When it reaches WAKE_CYCLES-1 -> ACTIVE. any_en dropping during WAKE does not abort the wake; after ACTIVE the idle logic applies.
- ACTIVE: amp_en = 1. !any_en -> DRAIN, with the idle counter cleared.
- DRAIN: amp_en = 1, PWM continues (duty naturally 0 once no voice is enabled).
  - any_en -> ACTIVE.
  - idle counter reaching IDLE_CYCLES-1 -> OFF.
  - If any_en and the timeout coincide, any_en wins (-> ACTIVE).
- amp_en is registered: it rises 1 cycle after entering WAKE and falls 1 cycle after entering OFF.

Boundary conditions:
- All voices enabled but all low -> duty 0, pwm_out constantly 0.
- vol_shift = 3 with a single voice at PWM_BITS=8 -> duty 32>>3 = 4.
- vol_shift changing mid-period takes effect only at the next duty load.
- Reset asserted mid-period forces outputs to reset values immediately.
- After rst_n deasserts, pwm_cnt restarts at 0 and the FSM at OFF.

Test Plan:
- Defaults, IDLE_CYCLES=100, WAKE_CYCLES=16. Reset, then voice_en=0 for 500 cycles -> amp_en=0, pwm_out=0 throughout, sample_stb pulses every 256 cycles.
- voice_en=8'h01 from OFF -> amp_en=1 one cycle later; pwm_out=0 for 16 cycles; then ACTIVE. With voice_sq[0] held 1 -> duty=32 at the next sample_stb; pwm_out high exactly 32 of 256 cycles per period.
- voice_en=voice_sq=8'hFF, vol_shift=0 -> duty=256, pwm_out high all 256 cycles. With vol_shift=2 -> duty=64, high 64 cycles. Change vol_shift mid-period -> the current period is unchanged.
- voice_en=8'h0F, voice_sq=8'h05 -> active_cnt=2, duty=64. Then voice_sq=8'h00 -> duty=0 from the next period.
- ACTIVE, drop voice_en to 0 -> DRAIN; amp_en stays 1 for 100 cycles, then 0. Repeat, re-asserting voice_en on the 100th idle cycle -> returns to ACTIVE, amp_en never falls.
- Assert rst_n low mid-period while pwm_out=1 -> pwm_out, amp_en, sample_stb go 0 without waiting for a clock edge. After release, pwm_cnt restarts from 0 and the FSM sits in OFF.
